// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud divisor helper
//
// Used by both the transmit and receive sides of the host UART.
//   uart_state_e  : serialiser states (IDLE, START, DATA, PARITY, STOP)
//   bps_cnt()     : clocks per bit for a given clock frequency and baud rate
//   UART_DATA_W   : data bits per frame
//   UART_IDLE_LVL : level of the idle line (mark)
package uart_pkg;

    localparam int   UART_DATA_W   = 8;
    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    function automatic int bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO buffering the UART transmitter
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (flushes the FIFO)
//   push_i, din_i     : write strobe and byte; ignored while full
//   pop_i             : read strobe; ignored while empty
//   dout_o            : head-of-queue byte (valid while not empty)
//   level_o           : entries held, 0..FIFO_DEPTH
//   full_o, empty_o   : status flags
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [UART_DATA_W-1:0] din_i,
    input  logic                   pop_i,
    output logic [UART_DATA_W-1:0] dout_o,
    output logic [LW-1:0]          level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    logic [UART_DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]          level_q;
    logic                   push_ok, pop_ok;

    assign full_o  = (level_q == LW'(FIFO_DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            // simultaneous push and pop leaves the level unchanged
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_send.sv
// rtl/uart_send.sv - UART transmitter (8 data bits, LSB first, 1 stop) with TX FIFO
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (mid-frame reset drops the frame)
//   tx_data     : byte to send, captured only on the push
//   tx_valid    : tx_data valid
//   tx_ready    : FIFO has room; transfer on tx_valid & tx_ready at posedge clk
//   uart_tx     : registered serial line, idle high
//   tx_busy     : serialiser not idle
//   tx_done     : one-cycle pulse on the last clock of each stop bit
//   fifo_level  : bytes buffered
// Build option: define UART_TX_PARITY_EN to append an even parity bit (8E1).
module uart_send
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int UART_BPS   = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   uart_tx,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic [2:0]             fifo_level
);

    localparam int          BPS_CNT  = bps_cnt(CLK_FREQ, UART_BPS);
    localparam logic [15:0] BIT_LAST = 16'(BPS_CNT - 1);
    localparam int          LW       = $clog2(FIFO_DEPTH) + 1;

    uart_state_e            state_q, state_d;
    logic [15:0]            clk_cnt_q, clk_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   uart_tx_q, uart_tx_d;
    logic                   tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    logic                   fifo_pop, fifo_full, fifo_empty;
    logic [UART_DATA_W-1:0] fifo_dout;
    logic [LW-1:0]          fifo_lvl;
    logic                   bit_end;

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_valid & tx_ready),
        .din_i   (tx_data),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .level_o (fifo_lvl),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tx_ready   = ~fifo_full;
    assign fifo_level = 3'(fifo_lvl);
    assign tx_busy    = (state_q != IDLE);
    assign uart_tx    = uart_tx_q;
    assign tx_done    = tx_done_q;
    assign bit_end    = (clk_cnt_q == BIT_LAST);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        tx_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        if (state_q != IDLE) clk_cnt_d = bit_end ? 16'd0 : clk_cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                clk_cnt_d = 16'd0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    par_d    = ^fifo_dout;
`endif
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    tx_done_d = 1'b1;
                    // chain straight into the next frame so back-to-back bytes have no idle gap
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                        par_d    = ^fifo_dout;
`endif
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the current state; registering it delays every bit by one
    // clock uniformly, so bit widths stay exactly BPS_CNT.
    always_comb begin
        uart_tx_d = UART_IDLE_LVL;
        case (state_q)
            START:   uart_tx_d = 1'b0;
            DATA:    uart_tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  uart_tx_d = par_q;
`endif
            default: uart_tx_d = UART_IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= '0;
            uart_tx_q <= UART_IDLE_LVL;
            tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            uart_tx_q <= uart_tx_d;
            tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_send.sv
// tb/tb_uart_send.sv - scoreboard bench for uart_send with a mid-bit serial checker
module tb_uart_send;

    localparam int CLK_FREQ = 1_000_000;
    localparam int UART_BPS = 100_000;
    localparam int BPS      = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * BPS;

    logic       clk, rst_n;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, uart_tx, tx_busy, tx_done;
    logic [2:0] fifo_level;

    uart_send #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    bit         abort_f = 1'b0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    always @(posedge clk) cyc++;
    always @(negedge clk) if (tx_done === 1'b1) done_cnt++;
    always @(negedge rst_n) abort_f = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serial checker: finds the start edge, samples each bit near its middle and
    // compares the recovered byte with the oldest accepted byte.
    initial begin : monitor
        logic       prev;
        logic [7:0] b;
        logic [7:0] e;
        logic       pbit;
        bit         ok;
        prev = 1'b1;
        b    = '0;
        pbit = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && prev === 1'b1 && uart_tx === 1'b0) begin
                abort_f = 1'b0;
                start_q.push_back(cyc);
                repeat (4) @(negedge clk);
                ok = !abort_f;
                if (ok) check("start_bit", uart_tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    if (ok) begin
                        repeat (BPS) @(negedge clk);
                        ok   = !abort_f;
                        b[i] = uart_tx;
                    end
                end
`ifdef UART_TX_PARITY_EN
                if (ok) begin
                    repeat (BPS) @(negedge clk);
                    ok   = !abort_f;
                    pbit = uart_tx;
                end
`endif
                if (ok) begin
                    repeat (BPS) @(negedge clk);
                    ok = !abort_f;
                end
                if (ok) begin
                    check("stop_bit", uart_tx, 1'b1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", b);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", b, e);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", pbit, ^e);
`endif
                    end
                end
            end
            prev = uart_tx;
        end
    end

    // Call at a negedge; returns at the negedge after the byte is accepted.
    task automatic push(input logic [7:0] d);
        int w;
        w = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (tx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: tx_ready %0b expected 1", tx_ready);
        end else begin
            @(posedge clk);
            exp_q.push_back(d);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || tx_busy !== 1'b0) && w < 40000) begin
            @(negedge clk);
            w++;
        end
        check("drain", (exp_q.size() == 0 && tx_busy === 1'b0), 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : main
        int         cnt;
        int         d0;
        logic [7:0] b [6];

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_ready", tx_ready, 1'b1);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // single byte from idle: latency and tx_done position
        push(8'hA5);
        check("t1_idle_0", uart_tx, 1'b1);
        @(negedge clk);
        check("t1_idle_1", uart_tx, 1'b1);
        @(negedge clk);
        check("t1_start_latency", uart_tx, 1'b0);
        repeat (FRAME - 2) @(negedge clk);
        check("t1_done_early", tx_done, 1'b0);
        @(negedge clk);
        check("t1_done_pulse", tx_done, 1'b1);
        @(negedge clk);
        check("t1_done_once", tx_done, 1'b0);
        check("t1_busy_idle", tx_busy, 1'b0);
        drain();

        // six bytes on consecutive cycles; fifth fills the FIFO
        d0 = done_cnt;
        start_q.delete();
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            tx_data  = b[i];
            tx_valid = 1'b1;
            check("t2_ready", tx_ready, 1'b1);
            @(posedge clk);
            exp_q.push_back(b[i]);
            @(negedge clk);
            check("t2_level", fifo_level, (i == 0) ? 3'd1 : 3'(i));
        end
        tx_data = b[5];
        check("t2_full_ready", tx_ready, 1'b0);
        cnt = 0;
        while (tx_ready !== 1'b1 && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("t2_ready_wait", cnt, FRAME - 3);
        @(posedge clk);
        exp_q.push_back(b[5]);
        @(negedge clk);
        tx_valid = 1'b0;
        drain();
        check("t2_frames", start_q.size(), 6);
        for (int k = 0; k + 1 < start_q.size(); k++)
            check("t2_no_gap", start_q[k+1] - start_q[k], FRAME);
        check("t2_done_cnt", done_cnt - d0, 6);

        // parity patterns and frame span
        start_q.delete();
        push(8'h07);
        push(8'h03);
        drain();
        check("t3_frames", start_q.size(), 2);
        if (start_q.size() == 2) check("t3_span", start_q[1] - start_q[0], FRAME);

        // reset during DATA bit 3 of 0xFF
        d0 = done_cnt;
        push(8'hFF);
        cnt = 0;
        while (uart_tx !== 1'b0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("t4_started", uart_tx, 1'b0);
        repeat (45) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_line", uart_tx, 1'b1);
        check("t4_rst_level", fifo_level, 3'd0);
        check("t4_rst_busy", tx_busy, 1'b0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (FRAME + 10) @(negedge clk);
        check("t4_no_done", done_cnt - d0, 0);
        push(8'h3C);
        drain();

        // random bytes with random valid gaps
        d0 = done_cnt;
        for (int i = 0; i < 256; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        check("t5_done_cnt", done_cnt - d0, 256);

        // push coinciding with the STOP-end pop at level 2
        push(8'h11);
        push(8'h22);
        push(8'h33);
        repeat (FRAME - 2) @(negedge clk);
        check("t6_level_pre", fifo_level, 3'd2);
        tx_data  = 8'h44;
        tx_valid = 1'b1;
        check("t6_ready", tx_ready, 1'b1);
        @(posedge clk);
        exp_q.push_back(8'h44);
        @(negedge clk);
        tx_valid = 1'b0;
        check("t6_level_same", fifo_level, 3'd2);
        check("t6_pop_cycle", tx_done, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
